// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: each channel produces a 50 % duty
// divided clock plus a one-cycle tick at every toggle, with shadowed divisor updates.
module clock_divider_multi #(
  parameter int          CH          = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 5_000_000,
  localparam int         WCH_W       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_wr_en,
  input  logic [WCH_W-1:0] i_wr_ch,
  input  logic [CNT_W-1:0] i_wr_div,
  input  logic [CH-1:0]    i_ch_en,
  input  logic             i_sync,
  output logic [CH-1:0]    o_clk,
  output logic [CH-1:0]    o_tick,
  output logic [CH-1:0]    o_pend,
  output logic             o_wr_err
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  // One extra bit so the channel range check stays meaningful when CH is a power of two.
  localparam logic [WCH_W:0]   CH_LIM  = (WCH_W + 1)'(CH);

  logic [CNT_W-1:0] cnt_q     [CH];
  logic [CNT_W-1:0] cnt_d     [CH];
  logic [CNT_W-1:0] act_div_q [CH];
  logic [CNT_W-1:0] act_div_d [CH];
  logic [CNT_W-1:0] sh_div_q  [CH];
  logic [CNT_W-1:0] sh_div_d  [CH];
  logic [CH-1:0]    pend_q, pend_d;
  logic [CH-1:0]    clk_q, clk_d;
  logic [CH-1:0]    tick_q, tick_d;
  logic             wr_err_q, wr_err_d;
  logic             wr_ok;

  always_comb begin
    wr_ok    = i_wr_en && (i_wr_div != '0) && ({1'b0, i_wr_ch} < CH_LIM);
    wr_err_d = i_wr_en && !wr_ok;
    pend_d   = pend_q;
    clk_d    = clk_q;
    tick_d   = '0;
    for (int k = 0; k < CH; k++) begin
      cnt_d[k]     = cnt_q[k];
      act_div_d[k] = act_div_q[k];
      sh_div_d[k]  = sh_div_q[k];

      // Sync and disable share the same restart; a pending shadow loads at once
      // because there is no half-period in flight that could be cut short.
      if (i_sync || !i_ch_en[k]) begin
        cnt_d[k] = '0;
        clk_d[k] = 1'b0;
        if (pend_q[k]) begin
          act_div_d[k] = sh_div_q[k];
          pend_d[k]    = 1'b0;
        end
      end else if (cnt_q[k] == act_div_q[k] - ONE) begin
        cnt_d[k]  = '0;
        clk_d[k]  = ~clk_q[k];
        tick_d[k] = 1'b1;
        if (pend_q[k]) begin
          act_div_d[k] = sh_div_q[k];
          pend_d[k]    = 1'b0;
        end
      end else begin
        cnt_d[k] = cnt_q[k] + ONE;
      end

      // A write landing on a load edge re-arms pending for the next terminal count.
      if (wr_ok && (i_wr_ch == WCH_W'(k))) begin
        sh_div_d[k] = i_wr_div;
        pend_d[k]   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < CH; k++) begin
        cnt_q[k]     <= '0;
        act_div_q[k] <= DEF_DIV;
        sh_div_q[k]  <= DEF_DIV;
      end
      pend_q   <= '0;
      clk_q    <= '0;
      tick_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        cnt_q[k]     <= cnt_d[k];
        act_div_q[k] <= act_div_d[k];
        sh_div_q[k]  <= sh_div_d[k];
      end
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign o_clk    = clk_q;
  assign o_tick   = tick_q;
  assign o_pend   = pend_q;
  assign o_wr_err = wr_err_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi with three channels, 8-bit counters and
// a reset divisor of 7; outputs are sampled 1 ns after each rising edge.
module tb_clock_divider_multi;

  localparam int CH    = 3;
  localparam int CNT_W = 8;
  localparam int DEFD  = 7;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [1:0]       wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic [CH-1:0]    ch_en;
  logic             sync;
  logic [CH-1:0]    o_clk;
  logic [CH-1:0]    o_tick;
  logic [CH-1:0]    o_pend;
  logic             o_wr_err;

  int checks;
  int failures;

  clock_divider_multi #(
    .CH(CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(DEFD)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_wr_en(wr_en),
    .i_wr_ch(wr_ch),
    .i_wr_div(wr_div),
    .i_ch_en(ch_en),
    .i_sync(sync),
    .o_clk(o_clk),
    .o_tick(o_tick),
    .o_pend(o_pend),
    .o_wr_err(o_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (o_clk !== 3'b000) begin failures++; $display("FAIL reset_clk got=%b exp=%b", o_clk, 3'b000); end
    checks++;
    if (o_tick !== 3'b000) begin failures++; $display("FAIL reset_tick got=%b exp=%b", o_tick, 3'b000); end
    checks++;
    if (o_pend !== 3'b000) begin failures++; $display("FAIL reset_pend got=%b exp=%b", o_pend, 3'b000); end
    checks++;
    if (o_wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%b exp=%b", o_wr_err, 1'b0); end
    rst_n = 1'b1;
  endtask

  // Write D=3 to ch0, enable: first period still uses the default 7, then D=3.
  task automatic test_basic_div3();
    logic exp_tick, exp_clk;
    ch_en = 3'b000;
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd3;
    step();
    wr_en = 1'b0;
    checks++;
    if (o_pend !== 3'b001) begin failures++; $display("FAIL basic_pend_set got=%b exp=%b", o_pend, 3'b001); end
    ch_en = 3'b001;
    for (int n = 1; n <= 6; n++) begin
      step();
      checks++;
      if ({o_tick[0], o_pend[0]} !== 2'b01) begin
        failures++; $display("FAIL basic_wait n=%0d tick_pend got=%b exp=%b", n, {o_tick[0], o_pend[0]}, 2'b01);
      end
    end
    step();
    checks++;
    if ({o_clk[0], o_tick[0], o_pend[0]} !== 3'b110) begin
      failures++; $display("FAIL basic_first_tc clk_tick_pend got=%b exp=%b", {o_clk[0], o_tick[0], o_pend[0]}, 3'b110);
    end
    for (int n = 8; n <= 19; n++) begin
      step();
      exp_tick = ((n - 7) % 3) == 0;
      exp_clk  = (((n - 7) / 3) % 2) == 0;
      checks++;
      if ({o_clk[0], o_tick[0]} !== {exp_clk, exp_tick}) begin
        failures++; $display("FAIL basic_div3 n=%0d clk_tick got=%b exp=%b", n, {o_clk[0], o_tick[0]}, {exp_clk, exp_tick});
      end
    end
  endtask

  // Ch0 at D=4; write D=2 while cnt=1: old half-period completes, then period 4.
  task automatic test_divisor_switch();
    logic [1:0] exp_ct [4];
    exp_ct[0] = 2'b00; exp_ct[1] = 2'b11; exp_ct[2] = 2'b10; exp_ct[3] = 2'b01;
    ch_en = 3'b000;
    step();
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd4;
    step();
    wr_en = 1'b0;
    step();
    checks++;
    if (o_pend[0] !== 1'b0) begin failures++; $display("FAIL switch_disabled_load pend got=%b exp=%b", o_pend[0], 1'b0); end
    ch_en = 3'b001;
    repeat (4) step();
    checks++;
    if ({o_clk[0], o_tick[0]} !== 2'b11) begin
      failures++; $display("FAIL switch_d4_tick clk_tick got=%b exp=%b", {o_clk[0], o_tick[0]}, 2'b11);
    end
    step();
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd2;
    step();
    wr_en = 1'b0;
    for (int n = 0; n < 2; n++) begin
      if (n > 0) step();
      checks++;
      if ({o_clk[0], o_tick[0], o_pend[0]} !== 3'b101) begin
        failures++; $display("FAIL switch_old_period n=%0d clk_tick_pend got=%b exp=%b", n, {o_clk[0], o_tick[0], o_pend[0]}, 3'b101);
      end
    end
    step();
    checks++;
    if ({o_clk[0], o_tick[0], o_pend[0]} !== 3'b010) begin
      failures++; $display("FAIL switch_load clk_tick_pend got=%b exp=%b", {o_clk[0], o_tick[0], o_pend[0]}, 3'b010);
    end
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if ({o_clk[0], o_tick[0]} !== exp_ct[n]) begin
        failures++; $display("FAIL switch_d2 n=%0d clk_tick got=%b exp=%b", n, {o_clk[0], o_tick[0]}, exp_ct[n]);
      end
    end
  endtask

  // D=0 and an out-of-range channel are both rejected; ch1 keeps the default divisor.
  task automatic test_wr_err();
    ch_en = 3'b000;
    step();
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd0;
    step();
    checks++;
    if (o_wr_err !== 1'b1) begin failures++; $display("FAIL wr_err_div0 got=%b exp=%b", o_wr_err, 1'b1); end
    checks++;
    if (o_pend !== 3'b000) begin failures++; $display("FAIL wr_err_div0_pend got=%b exp=%b", o_pend, 3'b000); end
    wr_ch = 2'd3; wr_div = 8'd5;
    step();
    checks++;
    if (o_wr_err !== 1'b1) begin failures++; $display("FAIL wr_err_badch got=%b exp=%b", o_wr_err, 1'b1); end
    checks++;
    if (o_pend !== 3'b000) begin failures++; $display("FAIL wr_err_badch_pend got=%b exp=%b", o_pend, 3'b000); end
    wr_en = 1'b0;
    step();
    checks++;
    if (o_wr_err !== 1'b0) begin failures++; $display("FAIL wr_err_clear got=%b exp=%b", o_wr_err, 1'b0); end
    ch_en = 3'b010;
    for (int n = 1; n <= 7; n++) begin
      step();
      checks++;
      if (o_tick[1] !== (n == 7)) begin
        failures++; $display("FAIL wr_err_ch1_default n=%0d tick got=%b exp=%b", n, o_tick[1], (n == 7));
      end
    end
    ch_en = 3'b000;
  endtask

  // Ch0/ch1 at D=5 started out of phase; sync realigns their ticks.
  task automatic test_sync();
    ch_en = 3'b000;
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd5;
    step();
    wr_ch = 2'd1;
    step();
    wr_en = 1'b0;
    step();
    checks++;
    if (o_pend !== 3'b000) begin failures++; $display("FAIL sync_setup_pend got=%b exp=%b", o_pend, 3'b000); end
    ch_en = 3'b001;
    repeat (2) step();
    ch_en = 3'b011;
    repeat (3) step();
    checks++;
    if (o_tick[1:0] !== 2'b01) begin failures++; $display("FAIL sync_skew tick got=%b exp=%b", o_tick[1:0], 2'b01); end
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++;
    if ({o_clk, o_tick} !== 6'b000000) begin
      failures++; $display("FAIL sync_edge clk_tick got=%b exp=%b", {o_clk, o_tick}, 6'b000000);
    end
    for (int n = 1; n <= 5; n++) begin
      step();
      checks++;
      if (o_tick[1:0] !== ((n == 5) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL sync_align n=%0d tick got=%b exp=%b", n, o_tick[1:0], ((n == 5) ? 2'b11 : 2'b00));
      end
    end
  endtask

  // D=1: tick held high, clock toggles every cycle.
  task automatic test_div1();
    ch_en = 3'b000;
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd1;
    step();
    wr_en = 1'b0;
    step();
    checks++;
    if (o_pend[2] !== 1'b0) begin failures++; $display("FAIL div1_pend got=%b exp=%b", o_pend[2], 1'b0); end
    ch_en = 3'b100;
    for (int n = 1; n <= 6; n++) begin
      step();
      checks++;
      if ({o_clk[2], o_tick[2]} !== {(n % 2) == 1, 1'b1}) begin
        failures++; $display("FAIL div1 n=%0d clk_tick got=%b exp=%b", n, {o_clk[2], o_tick[2]}, {(n % 2) == 1, 1'b1});
      end
    end
  endtask

  // Mid-count reset restores defaults; disabling ch0 mid-count restarts it from zero.
  task automatic test_reset_mid_and_disable();
    ch_en = 3'b111;
    repeat (3) step();
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd3;
    step();
    wr_en = 1'b0;
    checks++;
    if (o_pend !== 3'b010) begin failures++; $display("FAIL mid_pend got=%b exp=%b", o_pend, 3'b010); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({o_clk, o_tick, o_pend, o_wr_err} !== 10'd0) begin
      failures++; $display("FAIL mid_reset outs got=%b exp=%b", {o_clk, o_tick, o_pend, o_wr_err}, 10'd0);
    end
    for (int n = 1; n <= 7; n++) begin
      step();
      checks++;
      if (o_tick !== ((n == 7) ? 3'b111 : 3'b000)) begin
        failures++; $display("FAIL mid_default_div n=%0d tick got=%b exp=%b", n, o_tick, ((n == 7) ? 3'b111 : 3'b000));
      end
    end
    repeat (3) step();
    checks++;
    if (o_clk !== 3'b111) begin failures++; $display("FAIL mid_clk_high got=%b exp=%b", o_clk, 3'b111); end
    ch_en = 3'b110;
    step();
    checks++;
    if ({o_clk, o_tick} !== 6'b110000) begin
      failures++; $display("FAIL disable clk_tick got=%b exp=%b", {o_clk, o_tick}, 6'b110000);
    end
    ch_en = 3'b111;
    for (int n = 1; n <= 7; n++) begin
      step();
      checks++;
      if (o_tick[0] !== (n == 7)) begin
        failures++; $display("FAIL reenable n=%0d tick got=%b exp=%b", n, o_tick[0], (n == 7));
      end
    end
  endtask

  // Two writes before a load: only the last one takes effect.
  task automatic test_back_to_back();
    ch_en = 3'b000;
    step();
    ch_en = 3'b001;
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd9;
    step();
    wr_div = 8'd2;
    step();
    wr_en = 1'b0;
    repeat (4) step();
    checks++;
    if ({o_tick[0], o_pend[0]} !== 2'b01) begin
      failures++; $display("FAIL b2b_pending tick_pend got=%b exp=%b", {o_tick[0], o_pend[0]}, 2'b01);
    end
    step();
    checks++;
    if ({o_tick[0], o_pend[0]} !== 2'b10) begin
      failures++; $display("FAIL b2b_load tick_pend got=%b exp=%b", {o_tick[0], o_pend[0]}, 2'b10);
    end
    for (int n = 8; n <= 11; n++) begin
      step();
      checks++;
      if (o_tick[0] !== ((n % 2) == 1)) begin
        failures++; $display("FAIL b2b_last_wins n=%0d tick got=%b exp=%b", n, o_tick[0], ((n % 2) == 1));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = 2'd0;
    wr_div   = '0;
    ch_en    = 3'b000;
    sync     = 1'b0;
    test_reset();
    test_basic_div3();
    test_divisor_switch();
    test_wr_err();
    test_sync();
    test_div1();
    test_reset_mid_and_disable();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised multi-channel clock divider: CH independent channels derive slow divided clocks and single-cycle tick enables from one system clock. Each channel has a runtime-programmable divisor with glitch-free shadow update, a per-channel enable, and a global phase-align sync. It sits between the board clock and consumers such as FND scan, PWM timebase and debounce sampling, and replaces fixed-divisor dividers.

## Interface
- CH, 4, number of channels (1..16)
- CNT_W, 32, divisor and counter width
- DEFAULT_DIV, 5_000_000, reset divisor for every channel (must be 1..2^CNT_W-1)
- i_clk  in  1  system clock; all logic on rising edge
- i_reset_n  in  1  synchronous active-low reset, sampled on i_clk rising edge
- i_wr_en  in  1  divisor write strobe, one write per cycle
- i_wr_ch  in  max(1,$clog2(CH))  target channel of write
- i_wr_div  in  CNT_W  new divisor D (half-period in i_clk cycles)
- i_ch_en  in  CH  per-channel run enable, level sensitive
- i_sync  in  1  restart all channels in phase
- o_clk  out  CH  divided clock per channel, period 2·D, 50 % duty
- o_tick  out  CH  one-cycle pulse at every o_clk toggle (rate i_clk/D)
- o_pend  out  CH  1 = shadow divisor waiting to load
- o_wr_err  out  1  one-cycle pulse: last write rejected

## Operation
- Per channel: active divisor act_div, shadow sh_div, pending flag, counter cnt (CNT_W bits).
- Priority per edge: reset > i_sync > channel disabled > terminal count > count.
- Reset (i_reset_n=0): cnt=0, o_clk=0, o_tick=0, act_div=sh_div=DEFAULT_DIV, o_pend=0, o_wr_err=0.
- Count: i_ch_en[k]=1 and cnt≠act_div-1 → cnt+1, o_tick[k]=0.
- Terminal count: i_ch_en[k]=1 and cnt==act_div-1 → cnt=0, o_clk[k] toggles, o_tick[k]=1 for one cycle; if pending, act_div←sh_div and pending clears on this same edge.
- Disabled (i_ch_en[k]=0): cnt=0, o_clk[k]=0, o_tick[k]=0; pending shadow loads immediately.
- i_sync=1: every channel cnt=0, o_clk=0, o_tick=0, pending shadows load; enables ignored this edge.
- Write accepted when i_wr_en=1, i_wr_div≠0, i_wr_ch<CH: sh_div[ch]←i_wr_div, pending set. Visible to load logic from the next edge; a terminal count on the write edge uses the old pending state.
- Multiple writes before load: last write wins, single load.
- Write rejected (i_wr_div==0 or i_wr_ch≥CH): no state change, o_wr_err=1 next cycle.
- D=1: o_clk toggles every cycle, o_tick held high while enabled.
- Counter never exceeds act_div-1; no wrap beyond CNT_W.

## Timing
- All outputs registered; no combinational path input→output.
- Enable first sampled high at edge E1: cnt after edge En = n mod D; first o_tick and first o_clk rise after edge ED, i.e. D cycles latency.
- o_tick high exactly one cycle per D enabled cycles; o_clk high D cycles, low D cycles.
- New divisor takes effect on the terminal-count edge after the write; current half-period completes at the old D (no runt pulse).
- Disable: outputs 0 after the next edge; re-enable restarts from cnt=0.
- i_sync: all enabled channels with equal D produce coincident ticks D cycles after the sync edge.
- o_pend reflects the pending flag registered (updates on same edge as set/clear).
- o_wr_err asserted exactly one cycle per rejected write.

## Test plan
- Reset, write ch0 D=3, enable ch0 → o_tick[0] every 3rd cycle, o_clk[0] 3 high/3 low, o_pend[0] 1→0 at first terminal count after write.
- Ch0 running D=4; write D=2 with cnt=1 → two more old-period cycles, toggle, then o_clk period 4; o_pend[0] high in between.
- Write D=0 to ch1, then write ch=CH → two o_wr_err pulses, act_div/o_pend unchanged.
- Ch0 D=5, ch1 D=5 started 2 cycles apart; pulse i_sync → both o_tick coincide 5 cycles after sync edge.
- Write D=1 to ch2 and enable → o_tick[2] constant 1, o_clk[2] toggles every cycle.
- Mid-count i_reset_n=0 one cycle → all outputs 0 next cycle, divisors back to DEFAULT_DIV; deassert i_ch_en mid-count → o_clk=0 next cycle, re-enable gives first tick after D cycles.
